pipelined_reducer: RTL and testbench



---
 rtl/conv_pkg.sv | 15 +
 rtl/pipelined_reducer_tree.sv | 32 +++
 rtl/pipelined_reducer.sv | 126 ++++++++++++
 tb/tb_pipelined_reducer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared CONV-unit types: per-beat layer mode encoding and default datapath widths.
package conv_pkg;

  typedef enum logic [1:0] {
    POINTWISE   = 2'd0,
    GROUPED_3X3 = 2'd1,
    DEPTHWISE   = 2'd2,
    GROUPED_ALT = 2'd3
  } layer_type_t;

  localparam int CONV_IN_W  = 16;
  localparam int CONV_ACC_W = 32;
  localparam int CONV_OUT_W = 16;

endpackage

// File: rtl/pipelined_reducer_tree.sv
// Combinational COLS-input binary adder tree, zero-extending IN_W products to ACC_W.
// Latency 0; no flow control of its own (the enclosing stage register owns the handshake).
module reducer_tree
  import conv_pkg::*;
#(
  parameter int COLS  = 32,
  parameter int IN_W  = CONV_IN_W,
  parameter int ACC_W = CONV_ACC_W
) (
  input  logic [IN_W-1:0]  i_prod [COLS],
  output logic [ACC_W-1:0] o_sum
);

  localparam int LG = (COLS > 1) ? $clog2(COLS) : 0;

  // Level l holds COLS>>l partial sums; level LG is the root.
  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    logic [ACC_W-1:0] w_sum [COLS >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < COLS; i++) begin : g_in
        assign w_sum[i] = ACC_W'(i_prod[i]);
      end
    end else begin : g_add
      for (genvar i = 0; i < (COLS >> l); i++) begin : g_pair
        assign w_sum[i] = g_lvl[l-1].w_sum[2*i] + g_lvl[l-1].w_sum[2*i+1];
      end
    end
  end

  assign o_sum = g_lvl[LG].w_sum[0];

endmodule

// File: rtl/pipelined_reducer.sv
// Row/group reducer with ipsum accumulate and truncate/saturate: 2 register stages, 1 beat/cycle.
// Valid/ready on both sides; a stalled output holds 2 beats in flight before in_ready drops.
module pipelined_reducer
  import conv_pkg::*;
#(
  parameter int ROWS   = 32,
  parameter int COLS   = 32,
  parameter int IN_W   = CONV_IN_W,
  parameter int ACC_W  = CONV_ACC_W,
  parameter int OUT_W  = CONV_OUT_W,
  parameter int KGROUP = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  layer_type_t       layer_type,
  input  logic              ipsum_add_en,
  input  logic              sat_en,
  input  logic [IN_W-1:0]   mul_out_matrix [ROWS][COLS],
  input  logic [IN_W-1:0]   ipsum_out [ROWS],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  final_psum [ROWS],
  output logic              ovf
);

  localparam int NGRP = ROWS / KGROUP;
  localparam logic [ACC_W-1:0] LANE_MAX = ACC_W'({OUT_W{1'b1}});

  logic              r_s1_valid;
  logic [ACC_W-1:0]  r_row_sum [ROWS];
  layer_type_t       r_s1_mode;
  logic              r_s1_ipsum_en;
  logic              r_s1_sat_en;
  logic [IN_W-1:0]   r_s1_ipsum [ROWS];

  logic              r_out_valid;
  logic [OUT_W-1:0]  r_final_psum [ROWS];
  logic              r_ovf;

  logic              w_s2_ready;
  logic              w_s1_ready;
  logic              w_accept;
  logic [ACC_W-1:0]  w_row_sum [ROWS];
  logic [ACC_W-1:0]  w_pre [ROWS];
  logic [OUT_W-1:0]  w_final [ROWS];
  logic [ROWS-1:0]   w_lane_ovf;

  assign w_s2_ready = !r_out_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready && !rst;
  assign w_accept   = in_valid && in_ready;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    reducer_tree #(
      .COLS  (COLS),
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_tree (
      .i_prod (mul_out_matrix[r]),
      .o_sum  (w_row_sum[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  // Payload registers need no reset: they are only observed behind r_s1_valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_row_sum     <= w_row_sum;
      r_s1_mode     <= layer_type;
      r_s1_ipsum_en <= ipsum_add_en;
      r_s1_sat_en   <= sat_en;
      r_s1_ipsum    <= ipsum_out;
    end
  end

  for (genvar j = 0; j < ROWS; j++) begin : g_lane
    logic [ACC_W-1:0] w_grp_sum;
    logic [ACC_W-1:0] w_base;

    if (j < NGRP) begin : g_grp
      always_comb begin
        w_grp_sum = '0;
        for (int k = 0; k < KGROUP; k++) begin
          w_grp_sum = w_grp_sum + r_row_sum[j*KGROUP + k];
        end
      end
    end else begin : g_nogrp
      assign w_grp_sum = '0;
    end

    assign w_base        = (r_s1_mode == POINTWISE) ? r_row_sum[j] : w_grp_sum;
    assign w_pre[j]      = w_base + (r_s1_ipsum_en ? ACC_W'(r_s1_ipsum[j]) : '0);
    assign w_lane_ovf[j] = w_pre[j] > LANE_MAX;
    assign w_final[j]    = (r_s1_sat_en && w_lane_ovf[j]) ? {OUT_W{1'b1}} : w_pre[j][OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      for (int j = 0; j < ROWS; j++) begin
        r_final_psum[j] <= '0;
      end
    end else if (w_s2_ready) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_final_psum <= w_final;
        r_ovf        <= |w_lane_ovf;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign final_psum = r_final_psum;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_pipelined_reducer.sv
// Directed bench for pipelined_reducer: spec-level scoreboard model plus literal pins.
module tb_pipelined_reducer;
  import conv_pkg::*;

  localparam int ROWS = 32, COLS = 32, IN_W = 16, ACC_W = 32, OUT_W = 16, KGROUP = 3;
  localparam int NGRP = ROWS / KGROUP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  layer_type_t      layer_type = POINTWISE;
  logic             ipsum_add_en = 1'b0;
  logic             sat_en = 1'b0;
  logic [IN_W-1:0]  mul_out_matrix [ROWS][COLS];
  logic [IN_W-1:0]  ipsum_out [ROWS];
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] final_psum [ROWS];
  logic             ovf;

  pipelined_reducer #(
    .ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .KGROUP(KGROUP)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .layer_type(layer_type), .ipsum_add_en(ipsum_add_en), .sat_en(sat_en),
    .mul_out_matrix(mul_out_matrix), .ipsum_out(ipsum_out),
    .out_valid(out_valid), .out_ready(out_ready), .final_psum(final_psum), .ovf(ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [ROWS*OUT_W-1:0] act,
                           input logic [ROWS*OUT_W-1:0] exp);
    int lane;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      lane = 0;
      for (int j = ROWS - 1; j >= 0; j--)
        if (act[j*OUT_W +: OUT_W] !== exp[j*OUT_W +: OUT_W]) lane = j;
      $display("FAIL %s: lane %0d got %0d, expected %0d (t=%0t)", name, lane,
               act[lane*OUT_W +: OUT_W], exp[lane*OUT_W +: OUT_W], $time);
    end
  endtask

  // Reference: what the outputs must be for the beat currently on the inputs.
  function automatic void model(output logic [ROWS*OUT_W-1:0] fv, output logic fo);
    longint rs [ROWS];
    longint w;
    longint maxv;
    maxv = (64'd1 << OUT_W) - 1;
    fv = '0;
    fo = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      rs[r] = 0;
      for (int c = 0; c < COLS; c++) rs[r] += longint'(mul_out_matrix[r][c]);
    end
    for (int j = 0; j < ROWS; j++) begin
      if (layer_type == POINTWISE) w = rs[j];
      else if (j < NGRP) begin
        w = 0;
        for (int k = 0; k < KGROUP; k++) w += rs[j*KGROUP + k];
      end else w = 0;
      if (ipsum_add_en) w += longint'(ipsum_out[j]);
      w = w & ((64'd1 << ACC_W) - 1);
      if (w > maxv) begin
        fo = 1'b1;
        fv[j*OUT_W +: OUT_W] = sat_en ? OUT_W'(maxv) : OUT_W'(w);
      end else begin
        fv[j*OUT_W +: OUT_W] = OUT_W'(w);
      end
    end
  endfunction

  function automatic logic [ROWS*OUT_W-1:0] pack_out();
    logic [ROWS*OUT_W-1:0] v;
    for (int j = 0; j < ROWS; j++) v[j*OUT_W +: OUT_W] = final_psum[j];
    return v;
  endfunction

  logic [ROWS*OUT_W-1:0] exp_q [$];
  logic                  exp_ovf_q [$];
  int                    pin_lane_q [$];
  longint                pin_val_q [$];
  int                    pin_ovf_q [$];

  int     cur_pin_lane = -1;
  longint cur_pin_val = 0;
  int     cur_pin_ovf = -1;

  logic                  held = 1'b0;
  logic [ROWS*OUT_W-1:0] held_v;
  logic                  held_o;

  // Compare process: mid-cycle, both handshakes are stable.
  always @(negedge clk) begin
    logic [ROWS*OUT_W-1:0] dv, ev;
    logic eo;
    int pl, po;
    longint pv;
    if (rst) begin
      exp_q.delete(); exp_ovf_q.delete();
      pin_lane_q.delete(); pin_val_q.delete(); pin_ovf_q.delete();
      held = 1'b0;
    end else begin
      if (out_valid) begin
        dv = pack_out();
        if (held) begin
          check_vec("stall_psum_stable", dv, held_v);
          check("stall_ovf_stable", ovf, held_o);
        end
        if (out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_beat: got an output with %0d beats pending, required >= 1", exp_q.size());
          end else begin
            ev = exp_q.pop_front(); eo = exp_ovf_q.pop_front();
            pl = pin_lane_q.pop_front(); pv = pin_val_q.pop_front(); po = pin_ovf_q.pop_front();
            check_vec("beat_psum", dv, ev);
            check("beat_ovf", ovf, eo);
            if (pl >= 0) check($sformatf("pin_lane%0d", pl), final_psum[pl], pv);
            if (po >= 0) check("pin_ovf", ovf, po);
          end
        end else begin
          held = 1'b1; held_v = dv; held_o = ovf;
        end
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) begin
        model(ev, eo);
        exp_q.push_back(ev); exp_ovf_q.push_back(eo);
        pin_lane_q.push_back(cur_pin_lane); pin_val_q.push_back(cur_pin_val);
        pin_ovf_q.push_back(cur_pin_ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: every product = v; kind 1: row r products = r; kind 2: mixed pattern seeded by v.
  task automatic send(input int kind, input int v, input layer_type_t lt, input logic ipen,
                      input int ipv, input logic sat, input int pl, input longint pv, input int po);
    int n;
    for (int r = 0; r < ROWS; r++) begin
      ipsum_out[r] = IN_W'(ipv);
      for (int c = 0; c < COLS; c++)
        mul_out_matrix[r][c] = (kind == 0) ? IN_W'(v) : (kind == 1) ? IN_W'(r)
                             : IN_W'(r*131 + c*977 + v*4099);
    end
    layer_type = lt; ipsum_add_en = ipen; sat_en = sat;
    cur_pin_lane = pl; cur_pin_val = pv; cur_pin_ovf = po;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("send_accept_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      ipsum_out[r] = '0;
      for (int c = 0; c < COLS; c++) mul_out_matrix[r][c] = '0;
    end
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_psum0", final_psum[0], 0);
    check("rst_psum31", final_psum[31], 0);
    check("post_rst_in_ready", in_ready, 1);
    tick();

    // Pointwise all-ones, with a latency probe.
    send(0, 1, POINTWISE, 1'b0, 0, 1'b0, 31, 32, 0);
    @(negedge clk);
    check("latency_s1_out_valid", out_valid, 0);
    @(negedge clk);
    check("latency_s2_out_valid", out_valid, 1);
    tick();
    drain();

    // Grouped, row r = r, back-to-back with mode changes.
    send(1, 0, GROUPED_3X3, 1'b0, 0, 1'b0, 0, 96, 0);
    send(1, 0, DEPTHWISE,   1'b0, 0, 1'b0, 9, 2688, 0);
    send(1, 0, GROUPED_ALT, 1'b0, 0, 1'b0, 10, 0, 0);
    send(1, 0, GROUPED_3X3, 1'b1, 5, 1'b0, 0, 101, 0);
    send(1, 0, GROUPED_3X3, 1'b1, 5, 1'b0, 20, 5, 0);
    send(0, 1, POINTWISE,   1'b0, 0, 1'b0, 5, 32, 0);
    drain();

    // Saturate vs truncate, then mixed patterns.
    send(0, 16'hFFFF, POINTWISE,   1'b0, 0, 1'b1, 7, 16'hFFFF, 1);
    send(0, 16'hFFFF, POINTWISE,   1'b0, 0, 1'b0, 7, 16'hFFE0, 1);
    send(0, 16'hFFFF, GROUPED_3X3, 1'b1, 9, 1'b1, 12, 9, 1);
    send(2, 3, GROUPED_3X3, 1'b1, 100, 1'b1, -1, 0, -1);
    send(2, 9, POINTWISE,   1'b1, 40000, 1'b0, -1, 0, -1);
    drain();

    // Two beats held under back-pressure, then simultaneous accept + consume.
    out_ready = 1'b0;
    send(0, 7, POINTWISE,   1'b0, 0, 1'b0, 0, 224, 0);
    send(0, 8, GROUPED_3X3, 1'b0, 0, 1'b0, 0, 768, 0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    tick();
    tick();
    out_ready = 1'b1;
    send(0, 2, POINTWISE, 1'b0, 0, 1'b0, 3, 64, 0);
    drain();

    // Five beats, alternating modes, with a 4-cycle output stall mid-stream.
    fork
      begin
        for (int v = 1; v <= 5; v++)
          send(0, v, (v % 2 == 1) ? POINTWISE : GROUPED_3X3, 1'b0, 0, 1'b0,
               0, (v % 2 == 1) ? 32*v : 96*v, 0);
      end
      begin
        tick();
        tick();
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(0, 2, POINTWISE,   1'b0, 0, 1'b0, -1, 0, -1);
    send(0, 3, GROUPED_3X3, 1'b0, 0, 1'b0, -1, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    tick();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_psum0", final_psum[0], 0);
    check("midrst_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send(0, 4, POINTWISE, 1'b0, 0, 1'b0, 0, 128, 0);
    @(negedge clk);
    check("postrst_latency_s1", out_valid, 0);
    @(negedge clk);
    check("postrst_latency_s2", out_valid, 1);
    tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
